alu_4bit: RTL and testbench

//   Registered 4-bit integer ALU with 10 operations selected by a 4-bit opcode.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 52 +++++
 rtl/alu_4bit.sv | 47 ++++
 tb/tb_alu_4bit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered 4-bit ALU: the default operand width
// and the 4-bit opcode encodings decoded by alu_core.
// Contents:
//   DEFAULT_WIDTH  operand width used when a module is not overridden
//   OP_*           opcode values carried on the Sel port
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_GT  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_SUB = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath. Operands are unsigned and zero-extended
// to 2*WIDTH bits before evaluation, so every result is naturally truncated
// to the output width.
// Ports:
//   A    in   WIDTH     operand A
//   B    in   WIDTH     operand B, also the shift amount
//   Sel  in   4         opcode (see alu_pkg)
//   res  out  2*WIDTH   combinational result
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         Sel,
    output logic [2*WIDTH-1:0] res
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;

    assign a_ext = {{WIDTH{1'b0}}, A};
    assign b_ext = {{WIDTH{1'b0}}, B};

    // Shifts by an amount at or beyond the vector width yield zero in
    // SystemVerilog, which gives the required saturation-to-zero for SHL
    // (B >= 2*WIDTH) and SHR (B >= WIDTH, since the upper half is zero).
    // Unused opcodes drive zero so no X leaks downstream.
    always_comb begin
        res = '0;
        case (Sel)
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: res = a_ext - b_ext;
            OP_AND: res = a_ext & b_ext;
            OP_OR:  res = a_ext | b_ext;
            OP_XOR: res = a_ext ^ b_ext;
            OP_EQ:  res = {{(RW-1){1'b0}}, (A == B)};
            OP_GT:  res = {{(RW-1){1'b0}}, (A > B)};
            OP_SHL: res = a_ext << B;
            OP_SHR: res = a_ext >> B;
            OP_MUL: res = a_ext * b_ext;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------------------
// alu_4bit
// Registered 4-bit unsigned ALU. The combinational alu_core result is
// captured on every rising clock edge, giving one cycle of latency with a
// new operation accepted each cycle.
// Ports:
//   clk    in   1         clock, rising edge
//   rst_n  in   1         asynchronous reset, active-low; clears C at once
//   A      in   WIDTH     operand A, unsigned
//   B      in   WIDTH     operand B, unsigned; also the shift amount
//   Sel    in   4         opcode
//   C      out  2*WIDTH   registered result
// ---------------------------------------------------------------------------
module alu_4bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         Sel,
    output logic [2*WIDTH-1:0] C
);

    logic [2*WIDTH-1:0] res;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A   (A),
        .B   (B),
        .Sel (Sel),
        .res (res)
    );

    // Output register; asserting reset discards whatever result is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C <= '0;
        end else begin
            C <= res;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// ---------------------------------------------------------------------------
// tb_alu_4bit
// Directed self-checking bench for alu_4bit. Inputs are driven on the falling
// edge and C is sampled 1 ns after the following rising edge, with expected
// values written out by hand.
// ---------------------------------------------------------------------------
module tb_alu_4bit;

    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sel;
    logic [7:0] C;

    int checks;
    int errors;

    alu_4bit #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sel   (Sel),
        .C     (C)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 8'h%h, expected 8'h%h", tag, got, exp);
        end
    endtask

    // Drive an operation away from the active edge, then wait until it has
    // been registered and settled before returning
    task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        Sel = op;
        A   = a;
        B   = b;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: reset, each operation group, then a mid-stream reset
    initial begin
        checks = 0;
        errors = 0;
        A      = 4'd0;
        B      = 4'd0;
        Sel    = OP_ADD;
        rst_n  = 1'b1;

        // Reset held for two cycles with a non-zero operation on the inputs
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async", C, 8'h00);
        A   = 4'd3;
        B   = 4'd4;
        Sel = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 checkOutput("reset_hold", C, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("reset_release", C, 8'h00);

        // Arithmetic
        applyStimulus(OP_ADD, 4'd2, 4'd8);
        checkOutput("add_2_8", C, 8'h0A);
        applyStimulus(OP_ADD, 4'd15, 4'd15);
        checkOutput("add_15_15", C, 8'h1E);
        applyStimulus(OP_SUB, 4'd2, 4'd8);
        checkOutput("sub_2_8", C, 8'hFA);
        applyStimulus(OP_SUB, 4'd8, 4'd2);
        checkOutput("sub_8_2", C, 8'h06);
        applyStimulus(OP_SUB, 4'd0, 4'd15);
        checkOutput("sub_0_15", C, 8'hF1);

        // Bitwise logic
        applyStimulus(OP_AND, 4'hE, 4'h1);
        checkOutput("and_e_1", C, 8'h00);
        applyStimulus(OP_OR, 4'hE, 4'h1);
        checkOutput("or_e_1", C, 8'h0F);
        applyStimulus(OP_XOR, 4'hF, 4'h5);
        checkOutput("xor_f_5", C, 8'h0A);

        // Compares
        applyStimulus(OP_EQ, 4'd9, 4'd9);
        checkOutput("eq_9_9", C, 8'h01);
        applyStimulus(OP_EQ, 4'd9, 4'd5);
        checkOutput("eq_9_5", C, 8'h00);
        applyStimulus(OP_GT, 4'd15, 4'd7);
        checkOutput("gt_15_7", C, 8'h01);
        applyStimulus(OP_GT, 4'd7, 4'd15);
        checkOutput("gt_7_15", C, 8'h00);
        applyStimulus(OP_GT, 4'd6, 4'd6);
        checkOutput("gt_6_6", C, 8'h00);

        // Shifts
        applyStimulus(OP_SHL, 4'd8, 4'd7);
        checkOutput("shl_8_7", C, 8'h00);
        applyStimulus(OP_SHL, 4'd8, 4'd2);
        checkOutput("shl_8_2", C, 8'h20);
        applyStimulus(OP_SHL, 4'd3, 4'd6);
        checkOutput("shl_3_6", C, 8'hC0);
        applyStimulus(OP_SHL, 4'd1, 4'd8);
        checkOutput("shl_1_8", C, 8'h00);
        applyStimulus(OP_SHR, 4'd2, 4'd1);
        checkOutput("shr_2_1", C, 8'h01);
        applyStimulus(OP_SHR, 4'd2, 4'd5);
        checkOutput("shr_2_5", C, 8'h00);
        applyStimulus(OP_SHR, 4'hC, 4'd2);
        checkOutput("shr_c_2", C, 8'h03);

        // Multiply and unused opcodes
        applyStimulus(OP_MUL, 4'd11, 4'd7);
        checkOutput("mul_11_7", C, 8'h4D);
        applyStimulus(OP_MUL, 4'd15, 4'd15);
        checkOutput("mul_15_15", C, 8'hE1);
        applyStimulus(4'b0111, 4'd15, 4'd15);
        checkOutput("unused_0111", C, 8'h00);
        applyStimulus(4'b1001, 4'd9, 4'd3);
        checkOutput("unused_1001", C, 8'h00);

        // Mid-stream reset: C clears immediately and recovers after release
        applyStimulus(OP_MUL, 4'd11, 4'd7);
        checkOutput("mul_before_rst", C, 8'h4D);
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkOutput("midrst_async", C, 8'h00);
        #2 rst_n = 1'b1;
        #1 checkOutput("midrst_released", C, 8'h00);
        @(posedge clk);
        #1 checkOutput("midrst_recover", C, 8'h4D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
